// File: rtl/vga_pkg.sv
// Default 800x600 @ 60 Hz timing constants shared by the VGA timing generator.
package vga_pkg;

    localparam int CNT_W = 11;

    localparam int H_ACTIVE = 800;
    localparam int H_FP     = 40;
    localparam int H_SYNC   = 128;
    localparam int H_BP     = 88;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 600;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 4;
    localparam int V_BP     = 23;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

    localparam logic SYNC_POL = 1'b1;

endpackage

// File: rtl/vga_if.sv
// Pixel stream bundle passed from the timing generator through the draw stages.
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/vga_counter.sv
// Wrapping counter for one axis of the raster. Blank and sync flags are decoded
// from the next count and registered together with it, so they never lag the count.
module vga_counter
    import vga_pkg::*;
#(
    parameter int   TOTAL      = H_TOTAL,
    parameter int   ACTIVE     = H_ACTIVE,
    parameter int   SYNC_START = H_SYNC_START,
    parameter int   SYNC_END   = H_SYNC_END,
    parameter logic SYNC_ACT   = SYNC_POL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             last_o,
    output logic             blnk_o,
    output logic             sync_o
);

    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACTIVE_C = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SS_C     = CNT_W'(SYNC_START);
    localparam logic [CNT_W-1:0] SE_C     = CNT_W'(SYNC_END);

    logic [CNT_W-1:0] count_q, count_d;
    logic             blnk_q, blnk_d;
    logic             sync_q, sync_d;

    // last_o marks the terminal count; the parent uses it to chain axes.
    assign last_o = (count_q == LAST_C);

    // Next count and the flags that will describe it.
    always_comb begin
        count_d = last_o ? '0 : count_q + CNT_W'(1);
        blnk_d  = (count_d >= ACTIVE_C);
        sync_d  = ((count_d >= SS_C) && (count_d < SE_C)) ? SYNC_ACT : ~SYNC_ACT;
    end

    // Count and flags advance together; reset wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            blnk_q  <= 1'b0;
            sync_q  <= ~SYNC_ACT;
        end else if (en_i) begin
            count_q <= count_d;
            blnk_q  <= blnk_d;
            sync_q  <= sync_d;
        end
    end

    assign count_o = count_q;
    assign blnk_o  = blnk_q;
    assign sync_o  = sync_q;

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: drives hcount/vcount, sync and blanking for the
// draw pipeline and a one-cycle frame_start strobe for game logic.
module vga_timing
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int   H_FP     = vga_pkg::H_FP,
    parameter int   H_SYNC   = vga_pkg::H_SYNC,
    parameter int   H_BP     = vga_pkg::H_BP,
    parameter int   V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int   V_FP     = vga_pkg::V_FP,
    parameter int   V_SYNC   = vga_pkg::V_SYNC,
    parameter int   V_BP     = vga_pkg::V_BP,
    parameter logic SYNC_POL = vga_pkg::SYNC_POL
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    vga_if.out    vout,
    output logic  frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOT > 2048 || V_TOT > 2048) begin : g_bad_timing
            $error("vga_timing: H_TOTAL/V_TOTAL exceed the 11-bit counter range");
        end
    endgenerate

    logic [CNT_W-1:0] h_count, v_count;
    logic             h_last, v_last;
    logic             h_blnk, v_blnk;
    logic             h_sync, v_sync;
    logic             frame_start_q, frame_start_d;

    vga_counter #(
        .TOTAL     (H_TOT),
        .ACTIVE    (H_ACTIVE),
        .SYNC_START(H_ACTIVE + H_FP),
        .SYNC_END  (H_ACTIVE + H_FP + H_SYNC),
        .SYNC_ACT  (SYNC_POL)
    ) u_hcnt (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en),
        .count_o(h_count),
        .last_o (h_last),
        .blnk_o (h_blnk),
        .sync_o (h_sync)
    );

    // The vertical axis only steps on the pixel that wraps the line.
    vga_counter #(
        .TOTAL     (V_TOT),
        .ACTIVE    (V_ACTIVE),
        .SYNC_START(V_ACTIVE + V_FP),
        .SYNC_END  (V_ACTIVE + V_FP + V_SYNC),
        .SYNC_ACT  (SYNC_POL)
    ) u_vcnt (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en & h_last),
        .count_o(v_count),
        .last_o (v_last),
        .blnk_o (v_blnk),
        .sync_o (v_sync)
    );

    // Strobe when the raster wraps from the last pixel back to (0,0); a stall clears it.
    always_comb begin
        frame_start_d = en & h_last & v_last;
    end

    // Registered strobe so it lines up with the (0,0) counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_start_d;
        end
    end

    assign vout.hcount = h_count;
    assign vout.vcount = v_count;
    assign vout.hblnk  = h_blnk;
    assign vout.vblnk  = v_blnk;
    assign vout.hsync  = h_sync;
    assign vout.vsync  = v_sync;
    assign vout.rgb    = 12'h000;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a reduced-timing instance for whole-frame behaviour and
// a default-timing instance for the 800x600 line, both tracked by a raster model.
module tb_vga_timing;

    // Reduced timing: 32 pixels x 18 lines = 576 pixels per frame.
    localparam int S_HA = 16, S_HF = 4, S_HS = 6, S_HB = 6;
    localparam int S_VA = 12, S_VF = 1, S_VS = 2, S_VB = 3;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
    localparam int S_FT = S_HT * S_VT;

    localparam int D_HT = 1056;
    localparam int D_VT = 628;
    localparam int D_FT = D_HT * D_VT;

    logic clk, rst, en;
    logic fs_s, fs_d;

    vga_if vif_s ();
    vga_if vif_d ();

    vga_timing #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .SYNC_POL(1'b1)
    ) dut_s (
        .clk(clk), .rst(rst), .en(en), .vout(vif_s), .frame_start(fs_s)
    );

    vga_timing dut_d (
        .clk(clk), .rst(rst), .en(en), .vout(vif_d), .frame_start(fs_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Raster model: a linear pixel position within the frame.
    int pos_s = 0, pos_d = 0;
    bit fs_s_exp = 0, fs_d_exp = 0;
    int en_cnt = 0;

    typedef struct {
        int          ncyc;
        logic [10:0] h;
        logic [10:0] v;
        logic        hb, vb, hs, vs, fs;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [38:0] got, input logic [38:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [38:0] ref_vec(input int pos, input int ht, input int ha,
                                            input int hss, input int hse, input int va,
                                            input int vss, input int vse, input bit fs);
        int h = pos % ht;
        int v = pos / ht;
        logic hb = (h >= ha);
        logic vb = (v >= va);
        logic hs = (h >= hss) && (h < hse);
        logic vs = (v >= vss) && (v < vse);
        return {11'(h), 11'(v), hb, vb, hs, vs, fs, 12'h000};
    endfunction

    function automatic logic [38:0] dut_vec_s();
        return {vif_s.hcount, vif_s.vcount, vif_s.hblnk, vif_s.vblnk,
                vif_s.hsync, vif_s.vsync, fs_s, vif_s.rgb};
    endfunction

    function automatic logic [38:0] dut_vec_d();
        return {vif_d.hcount, vif_d.vcount, vif_d.hblnk, vif_d.vblnk,
                vif_d.hsync, vif_d.vsync, fs_d, vif_d.rgb};
    endfunction

    task automatic tick(input logic r, input logic e);
        rst = r;
        en  = e;
        @(posedge clk);
        if (r) begin
            pos_s = 0; pos_d = 0; fs_s_exp = 0; fs_d_exp = 0;
        end else if (e) begin
            fs_s_exp = (pos_s == S_FT - 1);
            fs_d_exp = (pos_d == D_FT - 1);
            pos_s = (pos_s + 1) % S_FT;
            pos_d = (pos_d + 1) % D_FT;
            en_cnt++;
        end else begin
            fs_s_exp = 0; fs_d_exp = 0;
        end
        #1;
        chk("stream_small", dut_vec_s(),
            ref_vec(pos_s, S_HT, S_HA, S_HA + S_HF, S_HA + S_HF + S_HS,
                    S_VA, S_VA + S_VF, S_VA + S_VF + S_VS, fs_s_exp));
        chk("stream_default", dut_vec_d(),
            ref_vec(pos_d, D_HT, 800, 840, 968, 600, 601, 605, fs_d_exp));
    endtask

    initial begin
        logic e;
        logic prev_hb;
        int   hb_rise_h, hs_cnt, line_len, pulses, k;
        bit   found;

        rst = 1'b1;
        en  = 1'b0;

        // Reset from power-up, advance to an arbitrary count, then hold reset 3 cycles.
        tick(1, 0);
        for (int i = 0; i < 57; i++) tick(0, 1);
        tick(1, 1);
        chk("reset_first_small", dut_vec_s(), 39'd0);
        chk("reset_first_default", dut_vec_d(), 39'd0);
        tick(1, 0);
        tick(1, 1);

        // Hand-derived checkpoints on the reduced raster: en cycles after reset -> outputs.
        vecs.push_back('{0,   11'd0,  11'd0,  0, 0, 0, 0, 0});
        vecs.push_back('{15,  11'd15, 11'd0,  0, 0, 0, 0, 0});
        vecs.push_back('{16,  11'd16, 11'd0,  1, 0, 0, 0, 0});
        vecs.push_back('{19,  11'd19, 11'd0,  1, 0, 0, 0, 0});
        vecs.push_back('{20,  11'd20, 11'd0,  1, 0, 1, 0, 0});
        vecs.push_back('{25,  11'd25, 11'd0,  1, 0, 1, 0, 0});
        vecs.push_back('{26,  11'd26, 11'd0,  1, 0, 0, 0, 0});
        vecs.push_back('{31,  11'd31, 11'd0,  1, 0, 0, 0, 0});
        vecs.push_back('{32,  11'd0,  11'd1,  0, 0, 0, 0, 0});
        vecs.push_back('{384, 11'd0,  11'd12, 0, 1, 0, 0, 0});
        vecs.push_back('{415, 11'd31, 11'd12, 1, 1, 0, 0, 0});
        vecs.push_back('{416, 11'd0,  11'd13, 0, 1, 0, 1, 0});
        vecs.push_back('{479, 11'd31, 11'd14, 1, 1, 0, 1, 0});
        vecs.push_back('{480, 11'd0,  11'd15, 0, 1, 0, 0, 0});
        vecs.push_back('{575, 11'd31, 11'd17, 1, 1, 0, 0, 0});
        vecs.push_back('{576, 11'd0,  11'd0,  0, 0, 0, 0, 1});
        vecs.push_back('{577, 11'd1,  11'd0,  0, 0, 0, 0, 0});
        foreach (vecs[i]) begin
            tick(1, 0);
            for (int c = 0; c < vecs[i].ncyc; c++) tick(0, 1);
            chk($sformatf("table_%0d", vecs[i].ncyc),
                {12'd0, vif_s.hcount, vif_s.vcount, vif_s.hblnk, vif_s.vblnk,
                 vif_s.hsync, vif_s.vsync, fs_s},
                {12'd0, vecs[i].h, vecs[i].v, vecs[i].hb, vecs[i].vb,
                 vecs[i].hs, vecs[i].vs, vecs[i].fs});
        end

        // Default 800x600 line: blank edge, sync width and line length.
        tick(1, 0);
        prev_hb = 1'b0; hb_rise_h = -1; hs_cnt = 0; line_len = -1;
        for (k = 1; k <= 2 * D_HT + 10; k++) begin
            tick(0, 1);
            if (!prev_hb && vif_d.hblnk && hb_rise_h < 0) hb_rise_h = int'(vif_d.hcount);
            prev_hb = vif_d.hblnk;
            if (vif_d.vcount == 11'd0 && vif_d.hsync) hs_cnt++;
            if (vif_d.vcount == 11'd1 && line_len < 0) begin
                line_len = k;
                chk("wrap_hcount", {28'd0, vif_d.hcount}, 39'd0);
            end
        end
        chk("hblnk_rise_at", 39'(hb_rise_h), 39'd800);
        chk("hsync_width", 39'(hs_cnt), 39'd128);
        chk("line_length", 39'(line_len), 39'd1056);

        // Stall just before hsync on the default raster.
        tick(1, 0);
        for (int i = 0; i < 839; i++) tick(0, 1);
        for (int i = 0; i < 10; i++) tick(0, 0);
        chk("stall_frozen", {26'd0, vif_d.hcount, vif_d.hsync, fs_d}, {26'd0, 11'd839, 1'b0, 1'b0});
        tick(0, 1);
        chk("stall_resume", {27'd0, vif_d.hcount, vif_d.hsync}, {27'd0, 11'd840, 1'b1});

        // Random enable over several reduced frames; frame_start period in en cycles.
        tick(1, 0);
        en_cnt = 0; pulses = 0;
        for (int i = 0; i < 6000 && pulses < 3; i++) begin
            e = ($urandom_range(0, 3) != 0);
            tick(0, e);
            if (fs_s === 1'b1) begin
                pulses++;
                chk("frame_period", 39'(en_cnt), 39'(S_FT));
                en_cnt = 0;
            end
        end
        chk("frame_pulses", 39'(pulses), 39'd3);

        // Mid-frame reset at (10,6) on the reduced raster.
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            e = ($urandom_range(0, 1) != 0);
            tick(0, e);
            if (pos_s == 6 * S_HT + 10) found = 1;
        end
        chk("midreset_reached", 39'(found), 39'd1);
        tick(1, 1);
        chk("midreset_counts", {16'd0, vif_s.hcount, vif_s.vcount, fs_s}, 39'd0);
        en_cnt = 0; found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            e = ($urandom_range(0, 3) != 0);
            tick(0, e);
            if (fs_s === 1'b1) found = 1;
        end
        chk("midreset_next_frame", 39'(en_cnt), 39'(S_FT));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Producer end of the vga_if pixel stream: generates hcount/vcount, hsync/vsync and hblnk/vblnk for every downstream draw stage.
- Draw stages consume this stream, register it and add rgb.
- Default timing is 800x600 @ 60 Hz, which needs a 40 MHz pixel clock.
- Also emits a one-cycle frame_start strobe for game-logic timing (bird physics, pipe scroll).

Parameters:
- H_ACTIVE, 800: visible pixels per line
- H_FP, 40: horizontal front porch
- H_SYNC, 128: hsync width
- H_BP, 88: horizontal back porch
- V_ACTIVE, 600: visible lines
- V_FP, 1: vertical front porch
- V_SYNC, 4: vsync width
- V_BP, 23: vertical back porch
- SYNC_POL, 1'b1: sync active level (1 = positive polarity)

Ports:
- clk  input  1  pixel clock, 40 MHz
- rst  input  1  reset, synchronous, active-high
- en  input  1  pixel enable; when low, all state holds
- vout  output  vga_if.out  vcount[10:0], vsync, vblnk, hcount[10:0], hsync, hblnk, rgb[11:0]
- frame_start  output  1  one-cycle pulse at the start of each frame

Behaviour:
- Constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (628).
- All outputs come straight from flops. No combinational path from inputs to outputs.
- Reset, synchronous, active-high. On the next edge:
  - hcount=0, vcount=0
  - hblnk=0, vblnk=0
  - hsync=~SYNC_POL, vsync=~SYNC_POL
  - rgb=0, frame_start=0
  - Reset has priority over en and takes effect mid-line or mid-frame with no cleanup.
- en=0: every flop holds its value. frame_start is forced to 0 (no repeated pulse while stalled).
- en=1, each edge:
  - hcount_nxt = (hcount==H_TOTAL-1) ? 0 : hcount+1
  - On the hcount wrap: vcount_nxt = (vcount==V_TOTAL-1) ? 0 : vcount+1. Otherwise vcount holds.
- Decode flags from the *next* counts and register them with the counts, so every flag is cycle-aligned with the hcount/vcount it describes (zero relative skew):
  - hblnk = hcount_nxt >= H_ACTIVE, i.e. 800..1055
  - hsync active = H_ACTIVE+H_FP <= hcount_nxt < H_ACTIVE+H_FP+H_SYNC, i.e. 840..967
  - vblnk = vcount_nxt >= V_ACTIVE, i.e. 600..627
  - vsync active = V_ACTIVE+V_FP <= vcount_nxt < V_ACTIVE+V_FP+V_SYNC, i.e. 601..604
  - vsync/vblnk change together with vcount on the edge where hcount goes 1055 -> 0. They do not change mid-line.
- frame_start = 1 for exactly the one cycle in which the registered counts are (0,0) after a wrap from (1055,627).
  - It is not asserted on the reset-exit cycle.
  - It is not asserted while en=0.
- rgb is always 12'h000; draw stages overwrite it.
- Counter width is 11 bits. Elaboration error (assertion) if H_TOTAL or V_TOTAL > 2048.
- Latency:
  - Each en=1 edge advances the stream by one pixel.
  - The first pixel after reset release is (0,0) and is visible.

Decomposition:
- vga_pkg holds the default timing constants (H_ACTIVE..V_BP, totals, sync start/end) and SYNC_POL. The module parameters default from the package.
- The vga_if definition is unchanged.
- Optional sub-module vga_counter: a generic wrapping counter with en, wrap output and a registered in-window flag. Instantiate it twice (horizontal and vertical).
- Total RTL for the block is roughly 150 lines.

Test Plan:
- Reset: hold rst 3 cycles at an arbitrary count. Required on the first edge: hcount=0, vcount=0, hsync=vsync=0, hblnk=vblnk=0, frame_start=0, rgb=0.
- Horizontal line:
  - hblnk rises when hcount=800.
  - hsync=1 for exactly 128 cycles at hcount 840..967.
  - Wrap 1055 -> 0 increments vcount by 1.
  - Exactly 1056 cycles per line.
- Vertical frame:
  - vblnk=1 on lines 600..627.
  - vsync=1 on lines 601..604 (4*1056 cycles).
  - Frame period is 663168 cycles.
  - frame_start pulses once, at (0,0), with period 663168.
- Enable stall: drop en for 10 cycles at hcount=839. Required: all outputs frozen and no frame_start. After en returns, hsync asserts on the next edge (hcount=840).
- Mid-frame reset: assert rst at (500,300). Counts return to (0,0) with no frame_start. The next frame_start occurs exactly 663168 en cycles later.
- Scoreboard over two full frames: hblnk, vblnk, hsync and vsync are checked against a reference decode of hcount/vcount every cycle, with zero tolerance for skew.
